// File: rtl/fetch_pkg.sv
// Shared types and constants for the IF stage: NOP encoding, FSM states, queue entry.
package fetch_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    // RUN: nothing outstanding; WAIT: granted, awaiting rvalid; DROP: outstanding response is wrong-path
    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
        return {a[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of {pc, instr} entries between fetch and ID; flush empties it in one cycle.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int QDEPTH = 2,
    localparam int AW = $clog2(QDEPTH),
    localparam int CW = AW + 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head,
    output logic [CW-1:0] count
);

    fetch_entry_t mem [QDEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;

    // Storage array: plain registers, no reset needed since count gates visibility
    always_ff @(posedge clk) begin
        if (push && !flush && !reset)
            mem[wr_ptr] <= push_data;
    end

    // Pointers and occupancy; power-of-2 depth lets pointers wrap naturally
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC ownership, single-outstanding imem fetch FSM, redirect flush, queue to ID.
// Optional FETCH_PERF_CNT_EN adds perf_fetch_cnt / perf_drop_cnt outputs.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic        CLK,
    input  logic        Reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        Redirect,
    input  logic [31:0] Redirect_PC,
    input  logic        id_Ready,
    output logic        out_Valid,
    output logic [31:0] out_Instr,
    output logic [31:0] out_PC
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_drop_cnt
`endif
);

    localparam int CW = $clog2(QDEPTH) + 1;

    fetch_state_e  state, state_nxt;
    logic [31:0]   fetch_pc;
    logic [31:0]   inflight_pc;
    logic [CW-1:0] count;
    fetch_entry_t  head;
    fetch_entry_t  push_data;
    logic          push;
    logic          pop;
    logic          discard;
    logic          fire;

    // FSM state register
    always_ff @(posedge CLK) begin
        if (Reset) state <= ST_RUN;
        else       state <= state_nxt;
    end

    // Next state, request and response routing; a response arriving with Redirect is discarded
    always_comb begin
        state_nxt = state;
        imem_req  = 1'b0;
        push      = 1'b0;
        discard   = 1'b0;
        case (state)
            ST_RUN: begin
                imem_req = !Redirect && !Reset && (count < CW'(QDEPTH));
                if (imem_req && imem_gnt) state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (imem_rvalid) begin
                    push      = !Redirect;
                    discard   = Redirect;
                    state_nxt = ST_RUN;
                end else if (Redirect) begin
                    state_nxt = ST_DROP;
                end
            end
            ST_DROP: begin
                if (imem_rvalid) begin
                    discard   = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    assign fire      = imem_req && imem_gnt;
    assign imem_addr = fetch_pc;
    assign pop       = out_Valid && id_Ready && !Redirect;

    // PC update: redirect wins over sequential advance
    always_ff @(posedge CLK) begin
        if (Reset) begin
            fetch_pc    <= RESET_PC;
            inflight_pc <= '0;
        end else if (Redirect) begin
            fetch_pc <= word_align(Redirect_PC);
        end else if (fire) begin
            inflight_pc <= fetch_pc;
            fetch_pc    <= fetch_pc + 32'd4;
        end
    end

    assign push_data = '{pc: inflight_pc, instr: imem_rdata};

    fetch_queue #(.QDEPTH(QDEPTH)) u_queue (
        .clk       (CLK),
        .reset     (Reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (Redirect),
        .head      (head),
        .count     (count)
    );

    assign out_Valid = (count != '0);
    assign out_Instr = out_Valid ? head.instr : NOP_INSTR;
    assign out_PC    = out_Valid ? head.pc    : 32'h0;

`ifdef FETCH_PERF_CNT_EN
    // Delivered instructions and wrong-path work (discarded responses plus flushed entries)
    always_ff @(posedge CLK) begin
        if (Reset) begin
            perf_fetch_cnt <= '0;
            perf_drop_cnt  <= '0;
        end else begin
            if (pop) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            perf_drop_cnt <= perf_drop_cnt + 32'(discard) + (Redirect ? 32'(count) : 32'd0);
        end
    end
`endif

endmodule
